// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU and its branch-resolution unit.
// The func and bru_func values match the control unit's decode.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111
   } alu_func_e;

   typedef enum logic [1:0] {
      BR_EQ = 2'b00,
      BR_NE = 2'b01,
      BR_LT = 2'b10,
      BR_GE = 2'b11
   } bru_func_e;

   // Subtract-style ops invert operand B and rely on carry_in at bit 0.
   function automatic logic is_sub_op(input logic [3:0] func);
      return (func == ALU_SUB) || (func == ALU_SLT) || (func == ALU_SLTU);
   endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Per-bit operand/result bundle between the control unit (master) and the
// bit-serial ALU (slave).
interface serial_alu_if;
   logic [3:0] func;
   logic [1:0] bru_func;
   logic       opA;
   logic       opB;
   logic       carry_in;
   logic       result;
   logic       slt;
   logic       branch;

   modport master (
      output func, bru_func, opA, opB, carry_in,
      input  result, slt, branch
   );

   modport slave (
      input  func, bru_func, opA, opB, carry_in,
      output result, slt, branch
   );
endinterface

// File: rtl/serial_branch_unit.sv
// Zero-detect accumulator and branch decision for the bit-serial ALU.
// Branch is valid on the bit-31 cycle, once every sum bit has been seen.
module serial_branch_unit
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sum,
   input  logic       slt,
   input  logic [1:0] bru_func,
   output logic       branch
);

   logic nz_q;
   logic nz;

   // Include the current bit so EQ/NE already reflect bit 31 on its own cycle.
   assign nz = nz_q | sum;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) nz_q <= 1'b0;
      else     nz_q <= nz;
   end

   // NOTE: default assignment first so no path through the case leaves branch unassigned (no latch).
   always_comb begin
      branch = 1'b0;
      case (bru_func)
         BR_EQ:   branch = ~nz;
         BR_NE:   branch = nz;
         BR_LT:   branch = slt;
         BR_GE:   branch = ~slt;
         default: branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU core: one operand bit pair per clock, LSB first, with
// carry state between bits and an attached branch-resolution unit.
module serial_alu
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   serial_alu_if.slave  bus
);

   logic sub;
   logic bi;
   logic c;
   logic sum;
   logic cout;
   logic carry_q;
   logic result_d;
   logic slt_d;

   assign sub  = is_sub_op(bus.func);
   assign bi   = bus.opB ^ sub;
   // carry_in still applies during a reset cycle; only the stored carry is cleared.
   assign c    = carry_q | bus.carry_in;
   assign sum  = bus.opA ^ bi ^ c;
   assign cout = (bus.opA & bi) | (bus.opA & c) | (bi & c);

   always_ff @(posedge clk) begin
      if (rst) carry_q <= 1'b0;
      else     carry_q <= cout;
   end

   always_comb begin
      result_d = bus.opA;
      case (bus.func)
         ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: result_d = sum;
         ALU_XOR:                            result_d = bus.opA ^ bus.opB;
         ALU_OR:                             result_d = bus.opA | bus.opB;
         ALU_AND:                            result_d = bus.opA & bus.opB;
         default:                            result_d = bus.opA;
      endcase
   end

   // On the MSB cycle: unsigned compare is the borrow, signed compare uses the
   // operand signs when they differ and the difference sign otherwise.
   always_comb begin
      if (bus.func == ALU_SLTU) slt_d = ~cout;
      else                      slt_d = (bus.opA ^ bus.opB) ? bus.opA : sum;
   end

   assign bus.result = result_d;
   assign bus.slt    = slt_d;

   serial_branch_unit u_branch (
      .clk      (clk),
      .rst      (rst),
      .sum      (sum),
      .slt      (slt_d),
      .bru_func (bus.bru_func),
      .branch   (bus.branch)
   );

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed cases plus randomized 32-bit
// operations compared against a word-level arithmetic reference model.
module tb_serial_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   serial_alu_if bus ();

   serial_alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (whole-word arithmetic) ----------------
   function automatic logic m_is_sub(input logic [3:0] f);
      return (f == 4'b1000) || (f == 4'b0010) || (f == 4'b0011);
   endfunction

   function automatic logic [32:0] m_sum33(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      if (m_is_sub(f)) return {1'b0, a} - {1'b0, b} + 33'h1_0000_0000;
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [31:0] m_result(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = m_sum33(f, a, b);
      case (f)
         4'b0000, 4'b1000, 4'b0010, 4'b0011: return s[31:0];
         4'b0100: return a ^ b;
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return a;
      endcase
   endfunction

   function automatic logic m_slt(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = m_sum33(f, a, b);
      if (f == 4'b0011) return a < b;
      if (m_is_sub(f))  return $signed(a) < $signed(b);
      return (a[31] != b[31]) ? a[31] : s[31];
   endfunction

   function automatic logic m_branch(input logic [3:0] f, input logic [1:0] bf, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = m_sum33(f, a, b);
      case (bf)
         2'b00:   return s[31:0] == 32'h0;
         2'b01:   return s[31:0] != 32'h0;
         2'b10:   return m_slt(f, a, b);
         default: return !m_slt(f, a, b);
      endcase
   endfunction

   // ---------------- driver: one reset cycle, then 32 bit cycles ----------------
   task automatic run_op(input logic [3:0] f, input logic [1:0] bf,
                         input logic [31:0] a, input logic [31:0] b, input int rst_at,
                         output logic [31:0] res, output logic slt_o, output logic br_o,
                         output logic [31:0] cq, output logic carry_end);
      rst          = 1'b1;
      bus.func     = f;
      bus.bru_func = bf;
      bus.opA      = 1'b0;
      bus.opB      = 1'b0;
      bus.carry_in = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         rst          = (i == rst_at);
         bus.opA      = a[i];
         bus.opB      = b[i];
         bus.carry_in = (i == 0) && m_is_sub(f);
         #1;
         res[i] = bus.result;
         cq[i]  = dut.carry_q;
         if (i == 31) begin
            slt_o = bus.slt;
            br_o  = bus.branch;
         end
         @(negedge clk);
      end
      rst          = 1'b0;
      bus.carry_in = 1'b0;
      #1;
      carry_end = dut.carry_q;
   endtask

   task automatic full_check(input string tag, input logic [3:0] f, input logic [1:0] bf,
                             input logic [31:0] a, input logic [31:0] b);
      logic [31:0] res, cq;
      logic        s, br, ce;
      logic [32:0] s33;
      run_op(f, bf, a, b, -1, res, s, br, cq, ce);
      s33 = m_sum33(f, a, b);
      check({tag, ".result"}, res, m_result(f, a, b));
      check({tag, ".slt"},    {31'b0, s},  {31'b0, m_slt(f, a, b)});
      check({tag, ".branch"}, {31'b0, br}, {31'b0, m_branch(f, bf, a, b)});
      check({tag, ".carry"},  {31'b0, ce}, {31'b0, s33[32]});
   endtask

   initial begin
      logic [31:0] res, cq, a, b, lo, hi;
      logic        s, br, ce;
      logic [3:0]  f;
      logic [1:0]  bf;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.func = ALU_ADD;  bus.bru_func = BR_EQ;
      bus.opA = 1'b0;  bus.opB = 1'b0;  bus.carry_in = 1'b0;
      @(negedge clk);

      // Reset state: no carry, no nonzero bit seen.
      rst = 1'b0;
      #1;
      check("reset.carry_q", {31'b0, dut.carry_q}, 32'h0);
      check("reset.result",  {31'b0, bus.result},  32'h0);
      check("reset.branch_eq", {31'b0, bus.branch}, 32'h1);
      @(negedge clk);

      // rst with carry_in: outputs see c=1, state still cleared.
      rst = 1'b1;  bus.opA = 1'b0;  bus.opB = 1'b0;  bus.carry_in = 1'b1;
      #1;
      check("rst_cin.result", {31'b0, bus.result}, 32'h1);
      bus.opA = 1'b1;
      #1;
      check("rst_cin.result_a1", {31'b0, bus.result}, 32'h0);
      @(negedge clk);
      rst = 1'b0;  bus.carry_in = 1'b0;  bus.opA = 1'b0;
      #1;
      check("rst_cin.cleared", {31'b0, bus.result}, 32'h0);
      @(negedge clk);

      // Directed cases.
      run_op(ALU_ADD, BR_EQ, 32'd5, 32'd3, -1, res, s, br, cq, ce);
      check("add5p3.result", res, 32'h0000_0008);
      check("add5p3.carry",  {31'b0, ce}, 32'h0);
      run_op(ALU_SUB, BR_EQ, 32'd3, 32'd5, -1, res, s, br, cq, ce);
      check("sub3m5.result", res, 32'hFFFF_FFFE);
      run_op(ALU_SUB, BR_EQ, 32'h1234, 32'h1234, -1, res, s, br, cq, ce);
      check("beq.result", res, 32'h0);
      check("beq.branch", {31'b0, br}, 32'h1);
      run_op(ALU_SLT, BR_GE, 32'hFFFF_FFFF, 32'h1, -1, res, s, br, cq, ce);
      check("slt.slt",    {31'b0, s},  32'h1);
      check("bge.branch", {31'b0, br}, 32'h0);
      run_op(ALU_SLTU, BR_LT, 32'hFFFF_FFFF, 32'h1, -1, res, s, br, cq, ce);
      check("sltu.slt", {31'b0, s}, 32'h0);
      run_op(ALU_XOR, BR_EQ, 32'hF0F0_A5A5, 32'h0FF0_FF00, -1, res, s, br, cq, ce);
      check("xor.result", res, 32'hFF00_5AA5);
      run_op(ALU_OR, BR_EQ, 32'hF0F0_A5A5, 32'h0FF0_FF00, -1, res, s, br, cq, ce);
      check("or.result", res, 32'hFFF0_FFA5);
      run_op(ALU_AND, BR_EQ, 32'hF0F0_A5A5, 32'h0FF0_FF00, -1, res, s, br, cq, ce);
      check("and.result", res, 32'h00F0_A500);
      run_op(ALU_SUB, BR_NE, 32'h8000_0000, 32'h0, -1, res, s, br, cq, ce);
      check("bne_msb.branch", {31'b0, br}, 32'h1);

      // Reset at bit 16: low bits continue the sum, upper bits restart without carry.
      a = 32'hFFFF_FFFF;  b = 32'h1;
      run_op(ALU_ADD, BR_EQ, a, b, 16, res, s, br, cq, ce);
      lo = (a + b) & 32'h0001_FFFF;
      hi = ((a >> 17) + (b >> 17)) << 17;
      check("midrst.carry_after", {31'b0, cq[17]}, 32'h0);
      check("midrst.result", res, hi | lo);
      check("midrst.carry_end", {31'b0, ce}, 32'h0);
      run_op(ALU_ADD, BR_EQ, 32'd1, 32'd1, -1, res, s, br, cq, ce);
      check("add1p1.result", res, 32'h0000_0002);

      // Random operations, including unused func codes and equal operands.
      for (int n = 0; n < 60; n++) begin
         f  = 4'($urandom_range(0, 15));
         if (n % 2 == 0) begin
            case ($urandom_range(0, 3))
               0: f = ALU_SUB;
               1: f = ALU_SLT;
               2: f = ALU_SLTU;
               default: f = ALU_ADD;
            endcase
         end
         bf = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
         full_check($sformatf("rand%0d_f%h_b%0d", n, f, bf), f, bf, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
